// File: rtl/reg_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_if
// Description : Bus bundle for the register-file writeback controller.
//               Carries the ALU path, the load handshake, the register-file
//               write port and the decode-side pending-write lookup.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_if #(
  parameter int PW    = 3,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // ALU result path (fixed priority, no backpressure)
  logic          alu_wr_en;
  logic [PW-1:0] alu_wr_addr;
  logic [7:0]    alu_dat;
  // Load result path (valid/ready)
  logic          ld_valid;
  logic          ld_ready;
  logic [PW-1:0] ld_addr;
  logic [7:0]    ld_dat;
  // Register file write port
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [7:0]    dat_in;
  // Pending-write lookup
  logic [PW-1:0] q_addr;
  logic          q_hit;
  logic [7:0]    q_dat;
  logic [CW-1:0] q_count;

  modport master (
    output alu_wr_en, alu_wr_addr, alu_dat,
    output ld_valid, ld_addr, ld_dat, q_addr,
    input  ld_ready, wr_en, wr_addr, dat_in, q_hit, q_dat, q_count
  );

  modport slave (
    input  alu_wr_en, alu_wr_addr, alu_dat,
    input  ld_valid, ld_addr, ld_dat, q_addr,
    output ld_ready, wr_en, wr_addr, dat_in, q_hit, q_dat, q_count
  );
endinterface
`default_nettype wire

// File: rtl/reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_ctrl
// Description : Writeback controller for a single-write-port register file.
//               ALU results win every cycle; load results go straight through
//               when the port is idle, otherwise wait in a small FIFO. ALU
//               writes squash older queued loads to the same register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_ctrl #(
  parameter int PW    = 3,
  parameter int DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  reg_wb_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Load FIFO storage; r_fv marks entries not yet squashed by a younger ALU write
  logic [PW-1:0]    r_fa [DEPTH];
  logic [7:0]       r_fd [DEPTH];
  logic [DEPTH-1:0] r_fv;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  // Registered register-file write port
  logic             r_wr_en;
  logic [PW-1:0]    r_wr_addr;
  logic [7:0]       r_dat_in;

  logic             w_empty;
  logic             w_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic             w_bypass;
  logic             w_hit;
  logic [7:0]       w_qdat;
  logic [AW-1:0]    w_idx;

  assign w_empty  = (r_count == '0);
  assign w_ready  = !reset && (r_count < CW'(DEPTH));
  assign w_accept = bus.ld_valid && w_ready;
  // The FIFO drains only on cycles the ALU leaves the port free
  assign w_pop    = !bus.alu_wr_en && !w_empty;
  // A load skips the FIFO only when nothing older is waiting and the port is free
  assign w_bypass = w_accept && !bus.alu_wr_en && w_empty;
  assign w_push   = w_accept && !w_bypass;

  // Output stage: pick ALU, FIFO head, bypassed load, or idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_dat_in  <= '0;
    end else if (bus.alu_wr_en) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= bus.alu_wr_addr;
      r_dat_in  <= bus.alu_dat;
    end else if (w_pop) begin
      // A squashed head still consumes the slot but produces no write
      r_wr_en <= r_fv[r_head];
      if (r_fv[r_head]) begin
        r_wr_addr <= r_fa[r_head];
        r_dat_in  <= r_fd[r_head];
      end
    end else if (w_bypass) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= bus.ld_addr;
      r_dat_in  <= bus.ld_dat;
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and squash of entries older than the ALU write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_fv    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.alu_wr_en && r_fv[i] && (r_fa[i] == bus.alu_wr_addr)) begin
          r_fv[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_fv[r_head] <= 1'b0;
        r_head       <= r_head + 1'b1;
      end
      // Push comes last: a load accepted alongside the ALU write is younger and stays valid
      if (w_push) begin
        r_fa[r_tail] <= bus.ld_addr;
        r_fd[r_tail] <= bus.ld_dat;
        r_fv[r_tail] <= 1'b1;
        r_tail       <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pending-write lookup: output stage is oldest, later FIFO matches override it
  always_comb begin
    w_hit  = 1'b0;
    w_qdat = '0;
    w_idx  = '0;
    if (r_wr_en && (r_wr_addr == bus.q_addr)) begin
      w_hit  = 1'b1;
      w_qdat = r_dat_in;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if ((CW'(k) < r_count) && r_fv[w_idx] && (r_fa[w_idx] == bus.q_addr)) begin
        w_hit  = 1'b1;
        w_qdat = r_fd[w_idx];
      end
    end
    if (reset) begin
      w_hit  = 1'b0;
      w_qdat = '0;
    end
  end

  assign bus.ld_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.dat_in   = r_dat_in;
  assign bus.q_hit    = w_hit;
  assign bus.q_dat    = w_qdat;
  assign bus.q_count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_ctrl
// Description : Self-checking bench for reg_wb_ctrl. Directed vector table,
//               a push/pop sequence, and random traffic against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_ctrl;
  localparam int PW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NTAB  = 29;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reg_wb_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

  reg_wb_ctrl #(.PW(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: queue of pending loads plus the write-port register
  typedef struct packed {
    logic [PW-1:0] a;
    logic [7:0]    d;
    logic          v;
  } ent_t;

  ent_t          mq[$];
  logic          m_wen;
  logic [PW-1:0] m_wa;
  logic [7:0]    m_wd;

  typedef struct {
    logic          rst;
    logic          ae;
    logic [PW-1:0] aa;
    logic [7:0]    ad;
    logic          lv;
    logic [PW-1:0] la;
    logic [7:0]    ld;
    logic [PW-1:0] qa;
    logic          e_rdy;
    logic          e_wen;
    logic [PW-1:0] e_wa;
    logic [7:0]    e_wd;
    logic [CW-1:0] e_cnt;
    logic          e_hit;
    logic [7:0]    e_qd;
  } vec_t;

  vec_t tab[NTAB];

  function automatic vec_t v(
    input logic rst, ae, input logic [PW-1:0] aa, input logic [7:0] ad,
    input logic lv, input logic [PW-1:0] la, input logic [7:0] ld, input logic [PW-1:0] qa,
    input logic e_rdy, e_wen, input logic [PW-1:0] e_wa, input logic [7:0] e_wd,
    input logic [CW-1:0] e_cnt, input logic e_hit, input logic [7:0] e_qd);
    vec_t r;
    r.rst = rst; r.ae = ae; r.aa = aa; r.ad = ad; r.lv = lv; r.la = la; r.ld = ld; r.qa = qa;
    r.e_rdy = e_rdy; r.e_wen = e_wen; r.e_wa = e_wa; r.e_wd = e_wd;
    r.e_cnt = e_cnt; r.e_hit = e_hit; r.e_qd = e_qd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Youngest valid queued load first, then the write-port register
  function automatic void m_look(input logic rst, input logic [PW-1:0] qa,
                                 output logic hit, output logic [7:0] d);
    hit = 1'b0;
    d   = '0;
    if (rst) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].v && mq[i].a == qa) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (m_wen && m_wa == qa) begin
      hit = 1'b1;
      d   = m_wd;
    end
  endfunction

  function automatic void m_step(input vec_t s);
    bit acc;
    ent_t e;
    if (s.rst) begin
      mq.delete();
      m_wen = 1'b0; m_wa = '0; m_wd = '0;
      return;
    end
    acc = s.lv && (mq.size() < DEPTH);
    if (s.ae) begin
      foreach (mq[i]) if (mq[i].a == s.aa) mq[i].v = 1'b0;
      m_wen = 1'b1; m_wa = s.aa; m_wd = s.ad;
      if (acc) mq.push_back('{s.la, s.ld, 1'b1});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = e.v;
      if (e.v) begin m_wa = e.a; m_wd = e.d; end
      if (acc) mq.push_back('{s.la, s.ld, 1'b1});
    end else if (acc) begin
      m_wen = 1'b1; m_wa = s.la; m_wd = s.ld;
    end else begin
      m_wen = 1'b0;
    end
  endfunction

  // Apply one cycle of inputs, compare mid-cycle, then advance model with the edge
  task automatic step(input vec_t s, input bit do_chk, input bit use_tab, input int idx);
    logic eh;
    logic [7:0] ed;
    reset           = s.rst;
    bus.alu_wr_en   = s.ae;
    bus.alu_wr_addr = s.aa;
    bus.alu_dat     = s.ad;
    bus.ld_valid    = s.lv;
    bus.ld_addr     = s.la;
    bus.ld_dat      = s.ld;
    bus.q_addr      = s.qa;
    #2;
    if (do_chk) begin
      m_look(s.rst, s.qa, eh, ed);
      chk("m_ld_ready", 32'(bus.ld_ready), 32'(!s.rst && mq.size() < DEPTH));
      chk("m_wr_en",    32'(bus.wr_en),    32'(m_wen));
      chk("m_wr_addr",  32'(bus.wr_addr),  32'(m_wa));
      chk("m_dat_in",   32'(bus.dat_in),   32'(m_wd));
      chk("m_q_count",  32'(bus.q_count),  32'(mq.size()));
      chk("m_q_hit",    32'(bus.q_hit),    32'(eh));
      chk("m_q_dat",    32'(bus.q_dat),    32'(ed));
    end
    if (use_tab) begin
      chk($sformatf("v%0d_ld_ready", idx), 32'(bus.ld_ready), 32'(s.e_rdy));
      chk($sformatf("v%0d_wr_en", idx),    32'(bus.wr_en),    32'(s.e_wen));
      chk($sformatf("v%0d_wr_addr", idx),  32'(bus.wr_addr),  32'(s.e_wa));
      chk($sformatf("v%0d_dat_in", idx),   32'(bus.dat_in),   32'(s.e_wd));
      chk($sformatf("v%0d_q_count", idx),  32'(bus.q_count),  32'(s.e_cnt));
      chk($sformatf("v%0d_q_hit", idx),    32'(bus.q_hit),    32'(s.e_hit));
      chk($sformatf("v%0d_q_dat", idx),    32'(bus.q_dat),    32'(s.e_qd));
    end
    @(posedge clk);
    m_step(s);
    #1;
  endtask

  initial begin
    vec_t s;
    //        rst ae aa ad     lv la ld     qa | rdy wen wa wd     cnt hit qd
    tab[0]  = v(1, 0, 0, 8'h00, 1, 1, 8'hFF, 0,   0, 0, 0, 8'h00, 0, 0, 8'h00);
    tab[1]  = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0, 8'h00);
    tab[2]  = v(0, 0, 0, 8'h00, 1, 5, 8'hA7, 5,   1, 0, 0, 8'h00, 0, 0, 8'h00);
    tab[3]  = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 5,   1, 1, 5, 8'hA7, 0, 1, 8'hA7);
    tab[4]  = v(0, 1, 2, 8'h11, 1, 3, 8'h22, 3,   1, 0, 5, 8'hA7, 0, 0, 8'h00);
    tab[5]  = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 3,   1, 1, 2, 8'h11, 1, 1, 8'h22);
    tab[6]  = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 3,   1, 1, 3, 8'h22, 0, 1, 8'h22);
    tab[7]  = v(0, 1, 0, 8'h30, 1, 1, 8'hC1, 1,   1, 0, 3, 8'h22, 0, 0, 8'h00);
    tab[8]  = v(0, 1, 0, 8'h31, 1, 2, 8'hC2, 1,   1, 1, 0, 8'h30, 1, 1, 8'hC1);
    tab[9]  = v(0, 1, 0, 8'h32, 1, 3, 8'hC3, 1,   1, 1, 0, 8'h31, 2, 1, 8'hC1);
    tab[10] = v(0, 1, 0, 8'h33, 1, 4, 8'hC4, 0,   1, 1, 0, 8'h32, 3, 1, 8'h32);
    tab[11] = v(0, 1, 0, 8'h34, 1, 5, 8'hC5, 0,   0, 1, 0, 8'h33, 4, 1, 8'h33);
    tab[12] = v(0, 0, 0, 8'h00, 1, 5, 8'hC5, 5,   0, 1, 0, 8'h34, 4, 0, 8'h00);
    tab[13] = v(0, 0, 0, 8'h00, 1, 5, 8'hC5, 5,   1, 1, 1, 8'hC1, 3, 0, 8'h00);
    tab[14] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 5,   1, 1, 2, 8'hC2, 3, 1, 8'hC5);
    tab[15] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,   1, 1, 3, 8'hC3, 2, 1, 8'hC4);
    tab[16] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,   1, 1, 4, 8'hC4, 1, 1, 8'hC4);
    tab[17] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 5,   1, 1, 5, 8'hC5, 0, 1, 8'hC5);
    tab[18] = v(0, 1, 1, 8'h10, 1, 6, 8'h55, 6,   1, 0, 5, 8'hC5, 0, 0, 8'h00);
    tab[19] = v(0, 1, 6, 8'h99, 0, 0, 8'h00, 6,   1, 1, 1, 8'h10, 1, 1, 8'h55);
    tab[20] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 6,   1, 1, 6, 8'h99, 1, 1, 8'h99);
    tab[21] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 6,   1, 0, 6, 8'h99, 0, 0, 8'h00);
    tab[22] = v(0, 1, 0, 8'h40, 1, 4, 8'h01, 4,   1, 0, 6, 8'h99, 0, 0, 8'h00);
    tab[23] = v(0, 1, 0, 8'h41, 1, 4, 8'h02, 4,   1, 1, 0, 8'h40, 1, 1, 8'h01);
    tab[24] = v(0, 1, 0, 8'h42, 0, 0, 8'h00, 4,   1, 1, 0, 8'h41, 2, 1, 8'h02);
    tab[25] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,   1, 1, 0, 8'h42, 2, 1, 8'h02);
    tab[26] = v(1, 0, 0, 8'h00, 1, 7, 8'h77, 4,   0, 1, 4, 8'h01, 1, 0, 8'h00);
    tab[27] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,   1, 0, 0, 8'h00, 0, 0, 8'h00);
    tab[28] = v(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,   1, 0, 0, 8'h00, 0, 0, 8'h00);

    // First reset edge brings DUT and model to a known state
    step(tab[0], 1'b0, 1'b0, -1);

    for (int i = 0; i < NTAB; i++) begin
      step(tab[i], 1'b1, 1'b1, i);
    end

    // Occupancy holds steady when a push and a pop share a cycle
    s = v(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(s, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      s = v(0, 1, 7, 8'(8'h50 + i), 1, 3'(i), 8'(8'hE0 + i), 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
      step(s, 1'b1, 1'b0, 0);
    end
    chk("fill_q_count", 32'(bus.q_count), 32'd3);
    for (int i = 0; i < 2; i++) begin
      s = v(0, 0, 0, 8'h00, 1, 3'(4 + i), 8'(8'hF0 + i), 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
      step(s, 1'b1, 1'b0, 0);
      chk($sformatf("pushpop%0d_q_count", i), 32'(bus.q_count), 32'd3);
    end
    chk("pushpop_wr_addr", 32'(bus.wr_addr), 32'd1);
    chk("pushpop_dat_in",  32'(bus.dat_in),  32'hE1);

    // Random traffic, occasional reset
    for (int n = 0; n < 3000; n++) begin
      s = v(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4),
            3'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)),
            0, 0, 0, 8'h00, 0, 0, 8'h00);
      step(s, 1'b1, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Writeback controller that drives the register file's single write port (wr_en, wr_addr, dat_in).
- Merges two result producers: the single-cycle ALU path, which has fixed priority, and the multi-cycle load path, which uses a valid/ready handshake.
- Load results that collide with ALU writes wait in a small FIFO.
- Exposes a pending-write lookup so decode can detect or forward results not yet in the register file.

Parameters:
pw, 3, register address pointer width (2**pw registers)
DEPTH, 4, load FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous active-high reset
alu_wr_en  in  1  ALU result valid this cycle (no backpressure)
alu_wr_addr  in  pw  ALU destination register
alu_dat  in  8  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid & ld_ready at posedge
ld_addr  in  pw  load destination register
ld_dat  in  8  load data
wr_en  out  1  register file write enable (registered)
wr_addr  out  pw  register file write pointer (registered)
dat_in  out  8  register file write data (registered)
q_addr  in  pw  lookup address from decode
q_hit  out  1  write to q_addr pending (combinational)
q_dat  out  8  data of youngest pending write to q_addr (combinational)
q_count  out  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (reset=1 at posedge): wr_en=0, wr_addr=0, dat_in=0, FIFO empty, all entry valid bits 0, q_count=0. While reset=1: ld_ready=0, q_hit=0, q_dat=0. Reset mid-operation discards all queued loads and the in-flight output write.
- ld_ready = !reset && (q_count < DEPTH). A load is accepted whenever ld_ready is high, even if the FIFO pops in the same cycle. No bypass of full.
- Per-cycle selection for the output stage (next wr_en/wr_addr/dat_in), in priority order:
  1. alu_wr_en=1: output ALU write. FIFO holds. An accepted load is enqueued.
  2. else FIFO non-empty: pop head. If the head entry is valid, output it; if it was squashed, wr_en=0 that cycle (slot consumed). An accepted load is enqueued.
  3. else FIFO empty and load accepted: bypass; output the load directly, nothing enqueued.
  4. else wr_en=0. wr_addr and dat_in hold their previous values.
- Latency: ALU and bypassed load 1 cycle (captured at the posedge after the input, written into the register file at the following posedge). Queued loads are written in FIFO order.
- Simultaneous push and pop: q_count unchanged. Pointers wrap modulo DEPTH.
- Squash: ALU results are younger than any outstanding load. When alu_wr_en=1, every valid FIFO entry with addr==alu_wr_addr has its valid bit cleared in the same cycle. A load accepted in the same cycle with ld_addr==alu_wr_addr is enqueued with valid=1, because it is younger than the ALU result.
- Squashed entries still count in q_count until popped.
- Lookup, search order (youngest first):
  1. Valid FIFO entries from tail-1 back to head.
  2. Then the output stage, if wr_en=1 and wr_addr==q_addr.
  - First match: q_hit=1, q_dat=its data. No match: q_hit=0, q_dat=0.
  - Squashed entries never hit.
- Register 0 is not special; writes to any address are forwarded as-is.

Test Plan:
- Reset: assert reset 2 cycles with ld_valid=1 -> wr_en=0, wr_addr=0, dat_in=0, ld_ready=0, q_count=0. After deassert, ld_ready=1.
- Bypass: idle, then load addr=5, dat=8'hA7 accepted -> next cycle wr_en=1, wr_addr=5, dat_in=8'hA7. q_count stays 0.
- Collision: ALU addr=2, dat=8'h11 and load addr=3, dat=8'h22 in the same cycle -> cycle+1 writes r2=8'h11, cycle+2 writes r3=8'h22. q_count goes 1 then 0. Check q_hit=1 / q_dat=8'h22 for q_addr=3 at cycle+1.
- Full: hold alu_wr_en=1 and offer 5 loads (addrs 1..5) -> first 4 accepted, ld_ready=0 with q_count=4, fifth held. Drop ALU -> loads written r1,r2,r3,r4, then r5, with back-to-back wr_en.
- Squash: queue load addr=6, dat=8'h55, then ALU addr=6, dat=8'h99 -> r6 written 8'h99. Queued entry pops with wr_en=0. q_addr=6 returns q_hit=0 once the output stage moves on.
- Forward priority: queue loads to r4 with 8'h01 then 8'h02 while ALU busy -> q_addr=4 gives q_hit=1, q_dat=8'h02. After the first pop, still 8'h02. Reset mid-queue -> q_hit=0 and no further writes.
